ntt_addr_gen_parallel: RTL and testbench
========================================

# ntt_addr_gen_parallel

Pipelined address and twiddle-index generator between the parallel NTT control FSM and the coefficient memory / butterfly array. Each cycle it takes the FSM schedule (stage, base butterfly index, per-lane valid) and produces, per lane, the two coefficient addresses and the twiddle-table index for a radix-2 Cooley-Tukey butterfly. It also flags the final beat of a transform and checks that every stage issued exactly N/2 butterflies.

## Interface
- N, default 256: transform size; power of two, ≥ 4.
- PARALLEL, default 8: butterfly lanes; power of two, 1..N/2.
- LOGN (localparam) = $clog2(N).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of pipeline, counter and sched_err.
- busy  in  1  FSM computing; schedule inputs qualified by it.
- stage  in  LOGN  current stage s, 0..LOGN-1.
- butterfly  in  LOGN-1  base butterfly index of this cycle (multiple of PARALLEL).
- lane_valid  in  PARALLEL  per-lane issue valid.
- addr_a  out  PARALLEL*LOGN  lane k at [k*LOGN +: LOGN]; top operand address.
- addr_b  out  PARALLEL*LOGN  lane k likewise; bottom operand address.
- tw_idx  out  PARALLEL*(LOGN-1)  lane k at [k*(LOGN-1) +: LOGN-1]; twiddle index.
- out_valid  out  PARALLEL  per-lane valid aligned with the address outputs.
- out_stage  out  LOGN  stage of the current output beat.
- out_last  out  1  final beat of the transform.
- sched_err  out  1  sticky schedule-count error.

## Operation
- Per lane k: j = butterfly + k (LOGN-1 bits, no wrap expected); len = 1 << s.
- group = j >> s; off = j & (len-1).
- addr_a = (group << (s+1)) | off; addr_b = addr_a + len (LOGN bits, never overflows for j < N/2).
- tw_idx = off << (LOGN-1-s).
- Lanes with out_valid[k]=0 have their address fields held at 0.
- out_last = 1 on the beat whose input had busy=1, stage=LOGN-1, and butterfly+PARALLEL ≥ N/2 with any lane valid.
- Inputs with busy=0 are treated as all lanes invalid.
- Pipeline: P1 registers j per lane, s, masked lane_valid and the last flag. P2 computes and registers all outputs. No stall; one beat per cycle.
- Stage checker (input side): registers prev_busy and prev_stage, plus cnt (LOGN bits, saturating at N/2+1) counting valid lanes in the current stage.
- End-of-stage event is prev_busy && (!busy || stage != prev_stage). On the event, if cnt != N/2, set sched_err.
- On the event, cnt reloads with popcount of the current valid lanes (0 if !busy); otherwise cnt accumulates.
- sched_err is sticky until clr or reset.
- clr is synchronous and takes priority: it zeroes P1/P2 valids, out_last, cnt, prev_busy and sched_err.

## Timing
- Latency 2 cycles: inputs sampled at edge t appear on outputs after edge t+2.
- Throughput: 1 beat per cycle, PARALLEL butterflies per beat.
- Reset (async, rst_n=0): all outputs 0 (addr_a, addr_b, tw_idx, out_valid, out_stage, out_last, sched_err); cnt, prev_busy, prev_stage also 0.
- Reset mid-transform drops in-flight beats; the first post-reset beat is the fresh input at edge t.
- out_valid/out_last go low 2 cycles after busy falls. The back-to-back final beat of one transform and first beat of the next are independent.
- Stage error is visible on sched_err the cycle after the end-of-stage edge. It is not pipeline-aligned with out_stage.
- A stage change while busy, with cnt exactly N/2, raises no error. Repeating a stage with full counts raises no error, since only counts are checked.

## Test plan
- N=16, P=4, reset → all outputs 0. Then busy=1, stage=0, butterfly=4, lane_valid=4'hF → 2 cycles later addr_a={14,12,10,8}, addr_b={15,13,11,9}, tw_idx=0, out_valid=4'hF. Lanes are listed 3..0.
- Stage 1, butterfly=4, lanes 0..3 → j=5 (lane 1) gives addr_a=9, addr_b=11, tw_idx=4; j=4 gives 8/10/0.
- Stage 3, butterfly=0 → lane 3: addr_a=3, addr_b=11, tw_idx=3. Butterfly=4, lane 1: addr_a=5, addr_b=13, tw_idx=5. out_last=1 only on the butterfly=4 beat, 2 cycles later.
- Full compliant schedule (4 stages × 2 beats, all lanes) → sched_err stays 0 and out_last pulses exactly once.
- Stage 2 with lane_valid=4'h7 on one beat (7 butterflies) → sched_err=1 after the stage-3 transition. It holds through the next transform; clr → 0 the next cycle.
- Assert rst_n=0 with beats in flight → outputs 0 immediately (asynchronously). After release, a new stage-0 beat emerges with 2-cycle latency and no stale out_valid.

Source files
------------

// File: rtl/ntt_addr_gen_parallel.sv
// Two-stage address / twiddle-index generator for a PARALLEL-lane radix-2 NTT,
// with an input-side checker that counts butterflies issued per stage.
module ntt_addr_gen_parallel #(
   parameter  int N        = 256,
   parameter  int PARALLEL = 8,
   localparam int LOGN     = $clog2(N)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_clr,
   input  logic                         i_busy,
   input  logic [LOGN-1:0]              i_stage,
   input  logic [LOGN-2:0]              i_butterfly,
   input  logic [PARALLEL-1:0]          i_lane_valid,
   output logic [PARALLEL*LOGN-1:0]     o_addr_a,
   output logic [PARALLEL*LOGN-1:0]     o_addr_b,
   output logic [PARALLEL*(LOGN-1)-1:0] o_tw_idx,
   output logic [PARALLEL-1:0]          o_out_valid,
   output logic [LOGN-1:0]              o_out_stage,
   output logic                         o_out_last,
   output logic                         o_sched_err
);

   localparam int BW   = LOGN - 1;
   localparam int HALF = N / 2;

   function automatic logic [LOGN-1:0] popcnt(input logic [PARALLEL-1:0] v);
      logic [LOGN-1:0] c;
      c = '0;
      for (int i = 0; i < PARALLEL; i++) c = c + LOGN'(v[i]);
      return c;
   endfunction

   // Saturates at HALF+1 so an over-issued stage can never wrap back to HALF.
   function automatic logic [LOGN-1:0] sat_add(input logic [LOGN-1:0] a,
                                                input logic [LOGN-1:0] b);
      logic [LOGN+1:0] s;
      s = {2'b00, a} + {2'b00, b};
      if (s > (LOGN+2)'(HALF + 1)) return LOGN'(HALF + 1);
      return s[LOGN-1:0];
   endfunction

   logic [PARALLEL-1:0]         w_vld;
   logic [LOGN-1:0]             w_pop;
   logic [LOGN-1:0]             w_bf_end;
   logic                        w_last;
   logic                        w_evt;

   logic [PARALLEL-1:0][BW-1:0] r_j_p1;
   logic [LOGN-1:0]             r_s_p1;
   logic [PARALLEL-1:0]         r_vld_p1;
   logic                        r_last_p1;

   logic [LOGN-1:0]             r_cnt;
   logic                        r_prev_busy;
   logic [LOGN-1:0]             r_prev_stage;

   logic [PARALLEL*LOGN-1:0]    w_addr_a;
   logic [PARALLEL*LOGN-1:0]    w_addr_b;
   logic [PARALLEL*BW-1:0]      w_tw;

   assign w_vld    = i_busy ? i_lane_valid : '0;
   assign w_pop    = popcnt(w_vld);
   assign w_bf_end = {1'b0, i_butterfly} + LOGN'(PARALLEL);
   assign w_last   = i_busy && (i_stage == LOGN'(LOGN - 1)) &&
                     (w_bf_end >= LOGN'(HALF)) && (|i_lane_valid);
   assign w_evt    = r_prev_busy && (!i_busy || (i_stage != r_prev_stage));

   // ---- P1: per-lane butterfly index, stage, masked valid, last flag ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_j_p1    <= '0;
         r_s_p1    <= '0;
         r_vld_p1  <= '0;
         r_last_p1 <= 1'b0;
      end else begin
         for (int k = 0; k < PARALLEL; k++) r_j_p1[k] <= i_butterfly + BW'(k);
         r_s_p1 <= i_stage;
         if (i_clr) begin
            r_vld_p1  <= '0;
            r_last_p1 <= 1'b0;
         end else begin
            r_vld_p1  <= w_vld;
            r_last_p1 <= w_last;
         end
      end
   end

   always_comb begin
      logic [BW-1:0]   mask;
      logic [BW-1:0]   off;
      logic [LOGN-1:0] grp;
      logic [LOGN-1:0] a;
      mask     = '0;
      off      = '0;
      grp      = '0;
      a        = '0;
      w_addr_a = '0;
      w_addr_b = '0;
      w_tw     = '0;
      // For the last stage the BW-wide mask wraps to all ones, which is exactly j.
      mask = (BW'(1) << r_s_p1) - BW'(1);
      for (int k = 0; k < PARALLEL; k++) begin
         if (r_vld_p1[k]) begin
            off = r_j_p1[k] & mask;
            grp = {1'b0, r_j_p1[k]} >> r_s_p1;
            a   = (grp << (r_s_p1 + LOGN'(1))) | {1'b0, off};
            w_addr_a[k*LOGN +: LOGN] = a;
            w_addr_b[k*LOGN +: LOGN] = a + (LOGN'(1) << r_s_p1);
            w_tw[k*BW +: BW]         = off << (LOGN'(LOGN - 1) - r_s_p1);
         end
      end
   end

   // ---- P2: registered outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_addr_a    <= '0;
         o_addr_b    <= '0;
         o_tw_idx    <= '0;
         o_out_valid <= '0;
         o_out_stage <= '0;
         o_out_last  <= 1'b0;
      end else begin
         o_out_stage <= r_s_p1;
         if (i_clr) begin
            o_addr_a    <= '0;
            o_addr_b    <= '0;
            o_tw_idx    <= '0;
            o_out_valid <= '0;
            o_out_last  <= 1'b0;
         end else begin
            o_addr_a    <= w_addr_a;
            o_addr_b    <= w_addr_b;
            o_tw_idx    <= w_tw;
            o_out_valid <= r_vld_p1;
            o_out_last  <= r_last_p1;
         end
      end
   end

   // ---- Stage checker on the input side ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_prev_busy  <= 1'b0;
         r_prev_stage <= '0;
         o_sched_err  <= 1'b0;
      end else if (i_clr) begin
         r_cnt        <= '0;
         r_prev_busy  <= 1'b0;
         r_prev_stage <= i_stage;
         o_sched_err  <= 1'b0;
      end else begin
         r_prev_busy  <= i_busy;
         r_prev_stage <= i_stage;
         if (w_evt) begin
            if (r_cnt != LOGN'(HALF)) o_sched_err <= 1'b1;
            r_cnt <= w_pop;
         end else begin
            r_cnt <= sat_add(r_cnt, w_pop);
         end
      end
   end

endmodule

// File: tb/tb_ntt_addr_gen_parallel.sv
// Randomized bench for ntt_addr_gen_parallel (N=16, PARALLEL=4) against an
// arithmetic reference model, plus hand-computed beats from the test plan.
module tb_ntt_addr_gen_parallel;

   localparam int N    = 16;
   localparam int P    = 4;
   localparam int LOGN = 4;
   localparam int HMAX = 4096;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr   = 1'b0;
   logic        busy  = 1'b0;
   logic [3:0]  stage = '0;
   logic [2:0]  bf    = '0;
   logic [3:0]  lv    = '0;

   logic [15:0] o_addr_a;
   logic [15:0] o_addr_b;
   logic [11:0] o_tw_idx;
   logic [3:0]  o_out_valid;
   logic [3:0]  o_out_stage;
   logic        o_out_last;
   logic        o_sched_err;

   ntt_addr_gen_parallel #(.N(N), .PARALLEL(P)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clr        (clr),
      .i_busy       (busy),
      .i_stage      (stage),
      .i_butterfly  (bf),
      .i_lane_valid (lv),
      .o_addr_a     (o_addr_a),
      .o_addr_b     (o_addr_b),
      .o_tw_idx     (o_tw_idx),
      .o_out_valid  (o_out_valid),
      .o_out_stage  (o_out_stage),
      .o_out_last   (o_out_last),
      .o_sched_err  (o_sched_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [15:0] h_a   [HMAX];
   logic [15:0] h_b   [HMAX];
   logic [11:0] h_tw  [HMAX];
   logic [3:0]  h_v   [HMAX];
   logic        h_last[HMAX];
   logic        h_err [HMAX];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: one record per accepted beat, delayed two cycles.
   typedef struct {
      bit [3:0] v;
      bit       last;
      int       s;
      int       bf;
   } beat_t;

   beat_t m1, m2, nb;
   int    m_cnt, m_ps, pop;
   bit    m_pb, m_err, evt;

   function automatic logic [15:0] f_addr(input beat_t b, input bit bottom);
      logic [15:0] r;
      int j, len, a;
      r = '0;
      for (int k = 0; k < P; k++) begin
         if (b.v[k]) begin
            j   = b.bf + k;
            len = 2 ** b.s;
            a   = (j / len) * 2 * len + (j % len);
            if (bottom) a = a + len;
            r[k*4 +: 4] = 4'(a);
         end
      end
      return r;
   endfunction

   function automatic logic [11:0] f_tw(input beat_t b);
      logic [11:0] r;
      int j, len, t;
      r = '0;
      for (int k = 0; k < P; k++) begin
         if (b.v[k]) begin
            j   = b.bf + k;
            len = 2 ** b.s;
            t   = (j % len) * (2 ** (LOGN - 1 - b.s));
            r[k*3 +: 3] = 3'(t);
         end
      end
      return r;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1    = '{default: 0};
         m2    = '{default: 0};
         m_cnt = 0;
         m_pb  = 0;
         m_ps  = 0;
         m_err = 0;
      end else begin
         nb.v    = busy ? lv : 4'h0;
         nb.s    = int'(stage);
         nb.bf   = int'(bf);
         nb.last = busy && (stage == 4'(LOGN - 1)) && (int'(bf) + P >= N / 2) && (lv != 0);
         m2 = m1;
         m1 = nb;
         pop = busy ? $countones(lv) : 0;
         if (clr) begin
            m1.v = 0; m1.last = 0;
            m2.v = 0; m2.last = 0;
            m_cnt = 0; m_pb = 0; m_err = 0;
         end else begin
            evt = m_pb && (!busy || int'(stage) != m_ps);
            if (evt) begin
               if (m_cnt != N / 2) m_err = 1;
               m_cnt = pop;
            end else begin
               m_cnt = m_cnt + pop;
            end
            m_pb = busy;
         end
         m_ps = int'(stage);
      end
   end

   always @(negedge clk) begin
      chk("addr_a",    o_addr_a,    f_addr(m2, 0));
      chk("addr_b",    o_addr_b,    f_addr(m2, 1));
      chk("tw_idx",    o_tw_idx,    f_tw(m2));
      chk("out_valid", o_out_valid, m2.v);
      chk("out_stage", o_out_stage, 4'(m2.s));
      chk("out_last",  o_out_last,  m2.last);
      chk("sched_err", o_sched_err, m_err);
      if (cyc < HMAX) begin
         h_a[cyc]    = o_addr_a;
         h_b[cyc]    = o_addr_b;
         h_tw[cyc]   = o_tw_idx;
         h_v[cyc]    = o_out_valid;
         h_last[cyc] = o_out_last;
         h_err[cyc]  = o_sched_err;
      end
   end

   task automatic drive(input bit c, input bit b, input int s, input int f,
                        input logic [3:0] l, output int e);
      clr   = c;
      busy  = b;
      stage = 4'(s);
      bf    = 3'(f);
      lv    = l;
      @(posedge clk);
      #1;
      e = cyc;
   endtask

   int ev[8];
   int e_tmp;

   // One full transform: 4 stages x 2 beats; stage 2's first beat uses lv2.
   task automatic xform(input logic [3:0] lv2);
      int e;
      for (int s = 0; s < LOGN; s++) begin
         for (int h = 0; h < 2; h++) begin
            drive(1'b0, 1'b1, s, h * P, (s == 2 && h == 0) ? lv2 : 4'hF, e);
            ev[s*2 + h] = e;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected end within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int n_last;
      int e_clr, e_a, e_b;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr_a",    o_addr_a,    16'h0);
      chk("rst_out_valid", o_out_valid, 4'h0);
      chk("rst_out_last",  o_out_last,  1'b0);
      chk("rst_sched_err", o_sched_err, 1'b0);
      rst_n = 1'b1;

      // Compliant transform with hand-computed beats.
      xform(4'hF);
      repeat (3) drive(1'b0, 1'b0, 0, 0, 4'h0, e_tmp);
      chk("s0b4_addr_a", h_a[ev[1]+1],  16'hECA8);
      chk("s0b4_addr_b", h_b[ev[1]+1],  16'hFDB9);
      chk("s0b4_tw",     h_tw[ev[1]+1], 12'h000);
      chk("s0b4_valid",  h_v[ev[1]+1],  4'hF);
      chk("s1b4_addr_a", h_a[ev[3]+1],  16'hDC98);
      chk("s1b4_addr_b", h_b[ev[3]+1],  16'hFEBA);
      chk("s1b4_tw",     h_tw[ev[3]+1], 12'h820);
      chk("s3b0_addr_a", h_a[ev[6]+1],  16'h3210);
      chk("s3b0_addr_b", h_b[ev[6]+1],  16'hBA98);
      chk("s3b0_tw",     h_tw[ev[6]+1], 12'h688);
      chk("s3b0_last",   h_last[ev[6]+1], 1'b0);
      chk("s3b4_addr_a", h_a[ev[7]+1],  16'h7654);
      chk("s3b4_addr_b", h_b[ev[7]+1],  16'hFEDC);
      chk("s3b4_tw",     h_tw[ev[7]+1], 12'hFAC);
      chk("s3b4_last",   h_last[ev[7]+1], 1'b1);
      n_last = 0;
      for (int c = ev[0]; c <= ev[7] + 3; c++) n_last += int'(h_last[c]);
      chk("last_pulses", n_last, 1);
      chk("good_sched_err", o_sched_err, 1'b0);

      // Short stage 2 (7 butterflies): error after the stage-3 transition.
      xform(4'h7);
      chk("short_err_before", h_err[ev[6]-1], 1'b0);
      chk("short_err_after",  h_err[ev[6]],   1'b1);
      drive(1'b0, 1'b0, 0, 0, 4'h0, e_tmp);
      xform(4'hF);
      drive(1'b0, 1'b0, 0, 0, 4'h0, e_tmp);
      chk("err_sticky", o_sched_err, 1'b1);
      drive(1'b1, 1'b0, 0, 0, 4'h0, e_clr);
      clr = 1'b0;
      chk("err_clr", h_err[e_clr], 1'b0);

      // Reset with beats in flight.
      drive(1'b0, 1'b1, 0, 0, 4'hF, e_tmp);
      drive(1'b0, 1'b1, 0, 4, 4'hF, e_tmp);
      chk("pre_rst_valid", o_out_valid, 4'hF);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid",  o_out_valid, 4'h0);
      chk("async_rst_addr_a", o_addr_a,    16'h0);
      chk("async_rst_addr_b", o_addr_b,    16'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 0, 4, 4'hF, e_a);
      repeat (3) drive(1'b0, 1'b0, 0, 0, 4'h0, e_b);
      chk("post_rst_stale", h_v[e_a],   4'h0);
      chk("post_rst_valid", h_v[e_a+1], 4'hF);
      chk("post_rst_addr",  h_a[e_a+1], 16'hECA8);
      drive(1'b1, 1'b0, 0, 0, 4'h0, e_tmp);

      // Randomized mix of compliant, faulty and arbitrary schedules.
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 3))
            0: xform(4'hF);
            1: begin
               for (int b = 0; b < 12; b++)
                  drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3), $urandom_range(0, 1) * P,
                        4'($urandom), e_tmp);
            end
            2: begin
               drive(1'b1, 1'b0, 0, 0, 4'h0, e_tmp);
               xform(4'hF);
            end
            default: xform(4'($urandom));
         endcase
         if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 0, 0, 4'h0, e_tmp);
      end
      repeat (3) drive(1'b0, 1'b0, 0, 0, 4'h0, e_tmp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
